// File: rtl/pipe_skp_pkg.sv
// Shared definitions for the PIPE SKP inserter.
//   SKP_SYMBOL  : K28.1 byte used to fill every SKP ordered set
//   skp_state_e : inserter FSM states
//   cnt_width() : symbol counter width for a given interval and word size
package pipe_skp_pkg;

  localparam logic [7:0] SKP_SYMBOL = 8'h3C;

  typedef enum logic {
    DATA = 1'b0,
    SKP  = 1'b1
  } skp_state_e;

  // Wide enough to hold the largest value the counter can reach:
  // one word short of the interval plus a full word.
  function automatic int cnt_width(input int interval, input int bytes);
    return $clog2(interval + bytes) + 1;
  endfunction

endpackage

// File: rtl/pipe_skp_fifo.sv
// Synchronous show-ahead FIFO for the SKP inserter input buffer.
// Ports:
//   clk, rst_n    : clock, async active-low reset (empties the FIFO)
//   push, wdata   : write strobe and word
//   pop, rdata    : read strobe; rdata always shows the head entry
//   full, empty   : occupancy flags, derived from the registered pointers
module pipe_skp_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pipe_skp_inserter.sv
// USB3 PIPE transmit SKP ordered-set inserter.
// Buffers upstream words, counts transmitted data symbols and, every
// SKP_INTERVAL symbols, emits a SKP ordered set (K28.1) at a word boundary
// while upstream is held off by the FIFO filling.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   enable                : SKP insertion enable (low = pass-through)
//   in_valid/in_ready     : upstream handshake; in_data/in_datak words
//   out_valid/out_ready   : PIPE-side handshake; out_data/out_datak = TxData/TxDataK
//   skp_active            : high while the output register holds a SKP word
//   skp_os_count          : completed SKP sets, saturating (only with
//                           PIPE_SKP_STATS_EN defined)
module pipe_skp_inserter
  import pipe_skp_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int SKP_INTERVAL   = 354,
  parameter int SKP_SYMBOLS    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BUS_WIDTH-1:0]   in_data,
  input  logic [DATA_BUS_WIDTH/8-1:0] in_datak,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BUS_WIDTH-1:0]   out_data,
  output logic [DATA_BUS_WIDTH/8-1:0] out_datak,
  output logic                        skp_active
`ifdef PIPE_SKP_STATS_EN
  ,
  output logic [15:0]                 skp_os_count
`endif
);

  localparam int BYTES     = DATA_BUS_WIDTH / 8;
  localparam int SKP_BEATS = SKP_SYMBOLS / BYTES;
  localparam int CW        = cnt_width(SKP_INTERVAL, BYTES);
  localparam int BW        = (SKP_BEATS > 1) ? $clog2(SKP_BEATS) : 1;
  localparam int FW        = DATA_BUS_WIDTH + BYTES;

  localparam logic [DATA_BUS_WIDTH-1:0] SKP_WORD = {BYTES{SKP_SYMBOL}};

  skp_state_e                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_add;
  logic [BW-1:0]              beat_q, beat_d;
  logic                       ov_q, ov_d;
  logic [DATA_BUS_WIDTH-1:0]  od_q, od_d;
  logic [BYTES-1:0]           ok_q, ok_d;
  logic                       rdy_en_q;

  logic                       f_push, f_pop, f_full, f_empty;
  logic [FW-1:0]              f_rdata, src_word;
  logic                       push, xfer, boundary, src_avail, skp_req, take, set_done;

  // ---------------------------------------------------------------- input FIFO
  pipe_skp_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .wdata ({in_datak, in_data}),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  // rdy_en_q keeps in_ready low through reset and for the first cycle after.
  assign in_ready  = rdy_en_q & ~f_full;
  assign push      = in_valid & in_ready;
  assign xfer      = ov_q & out_ready;
  assign boundary  = ~ov_q | out_ready;

  // An empty FIFO is bypassed so a fresh word reaches the output a cycle
  // after it is accepted; order is kept because bypass needs an empty FIFO.
  assign src_avail = ~f_empty | push;
  assign src_word  = f_empty ? {in_datak, in_data} : f_rdata;
  assign f_pop     = take & ~f_empty;
  assign f_push    = push & ~(take & f_empty);

  // Counter value including the word leaving this cycle, so the set goes out
  // right behind the word that crossed the interval.
  assign cnt_add = cnt_q + ((xfer && state_q == DATA) ? CW'(BYTES) : CW'(0));
  assign skp_req = enable && (cnt_add >= CW'(SKP_INTERVAL));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = enable ? cnt_add : '0;
    beat_d   = beat_q;
    ov_d     = ov_q & ~out_ready;
    od_d     = od_q;
    ok_d     = ok_q;
    take     = 1'b0;
    set_done = 1'b0;
    case (state_q)
      DATA: begin
        if (boundary) begin
          if (skp_req) begin
            state_d = SKP;
            cnt_d   = '0;
            beat_d  = '0;
            ov_d    = 1'b1;
            od_d    = SKP_WORD;
            ok_d    = '1;
          end else if (src_avail) begin
            take         = 1'b1;
            ov_d         = 1'b1;
            {ok_d, od_d} = src_word;
          end
        end
      end
      SKP: begin
        // enable is ignored here so a set is never truncated.
        if (xfer) begin
          if (beat_q == BW'(SKP_BEATS - 1)) begin
            state_d  = DATA;
            set_done = 1'b1;
            if (src_avail) begin
              take         = 1'b1;
              ov_d         = 1'b1;
              {ok_d, od_d} = src_word;
            end
          end else begin
            beat_d = beat_q + BW'(1);
            ov_d   = 1'b1;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DATA;
      cnt_q    <= '0;
      beat_q   <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ok_q     <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      ok_q     <= ok_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_datak  = ok_q;
  assign skp_active = (state_q == SKP);

`ifdef PIPE_SKP_STATS_EN
  logic [15:0] os_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            os_cnt_q <= '0;
    else if (set_done && os_cnt_q != '1)   os_cnt_q <= os_cnt_q + 16'd1;
  end
  assign skp_os_count = os_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skp_inserter.sv
// Scoreboard bench for pipe_skp_inserter: a 32-bit and an 8-bit instance.
// Drivers push expected words (and SKP beats at each interval crossing) into
// per-instance queues; monitors pop and compare on every output transfer.
module tb_pipe_skp_inserter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        en32, v32, r32, ov32, or32, sk32;
  logic [31:0] d32, od32;
  logic [3:0]  k32, ok32;
  // 8-bit instance
  logic        en8, v8, r8, ov8, or8, sk8, k8, ok8;
  logic [7:0]  d8, od8;
`ifdef PIPE_SKP_STATS_EN
  logic [15:0] os32, os8;
`endif

  pipe_skp_inserter #(.DATA_BUS_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .enable(en32),
    .in_valid(v32), .in_ready(r32), .in_data(d32), .in_datak(k32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_datak(ok32),
    .skp_active(sk32)
`ifdef PIPE_SKP_STATS_EN
    , .skp_os_count(os32)
`endif
  );

  pipe_skp_inserter #(.DATA_BUS_WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(en8),
    .in_valid(v8), .in_ready(r8), .in_data(d8), .in_datak(k8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_datak(ok8),
    .skp_active(sk8)
`ifdef PIPE_SKP_STATS_EN
    , .skp_os_count(os8)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Entries are {skp_active, datak, data}.
  logic [36:0] q32[$];
  logic [9:0]  q8[$];
  int bytes32 = 0, bytes8 = 0;
  int skp32_seen = 0, pre32 = 0, skp8_seen = 0, pre8 = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected-stream model: a SKP set follows the word that brings the
  // transmitted byte count to 354 or more; enable low keeps the count at 0.
  task automatic exp32(input logic [31:0] d, input logic [3:0] k);
    q32.push_back({1'b0, k, d});
    if (en32) begin
      bytes32 += 4;
      if (bytes32 >= 354) begin
        q32.push_back({1'b1, 4'hF, 32'h3C3C3C3C});
        bytes32 = 0;
      end
    end else bytes32 = 0;
  endtask

  task automatic exp8(input logic [7:0] d, input logic k);
    q8.push_back({1'b0, k, d});
    if (en8) begin
      bytes8 += 1;
      if (bytes8 >= 354) begin
        for (int b = 0; b < 4; b++) q8.push_back({1'b1, 1'b1, 8'h3C});
        bytes8 = 0;
      end
    end else bytes8 = 0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] k);
    int n = 0;
    v32 = 1'b1; d32 = d; k32 = k;
    @(negedge clk);
    while (!r32 && n < 200) begin n++; @(negedge clk); end
    if (!r32) begin
      n_chk++; n_err++;
      $display("FAIL u32_send_timeout: in_ready got 0 required 1");
    end else exp32(d, k);
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic k);
    int n = 0;
    v8 = 1'b1; d8 = d; k8 = k;
    @(negedge clk);
    while (!r8 && n < 200) begin n++; @(negedge clk); end
    if (!r8) begin
      n_chk++; n_err++;
      $display("FAIL u8_send_timeout: in_ready got 0 required 1");
    end else exp8(d, k);
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      n_chk++; n_err++;
      $display("FAIL %s_drain: pending got %0d required 0", tag, q32.size() + q8.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_skp8(input string tag);
    int n = 0;
    @(negedge clk);
    while (!sk8 && n < 100) begin n++; @(negedge clk); end
    if (!sk8) begin
      n_chk++; n_err++;
      $display("FAIL %s: skp_active got 0 required 1", tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q32.delete(); q8.delete();
    bytes32 = 0; bytes8 = 0;
    skp32_seen = 0; pre32 = 0; skp8_seen = 0; pre8 = 0;
    en32 = 1'b1; en8 = 1'b1; v32 = 1'b0; v8 = 1'b0; or32 = 1'b1; or8 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- monitors
  logic [36:0] e32;
  logic [9:0]  e8;

  initial forever begin
    @(negedge clk);
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL u32_extra_word: got %h expected none", od32);
      end else begin
        e32 = q32.pop_front();
        chk("u32_word", 64'({sk32, ok32, od32}), 64'(e32));
      end
      if (sk32) skp32_seen++;
      else if (skp32_seen == 0) pre32++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL u8_extra_word: got %h expected none", od8);
      end else begin
        e8 = q8.pop_front();
        chk("u8_word", 64'({sk8, ok8, od8}), 64'(e8));
      end
      if (sk8) skp8_seen++;
      else if (skp8_seen == 0) pre8++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [35:0] cap;
  bit          stable;
  int          acc;

  initial begin
    en32 = 1'b1; en8 = 1'b1; v32 = 1'b0; v8 = 1'b0; or32 = 1'b1; or8 = 1'b1;
    d32 = '0; k32 = '0; d8 = '0; k8 = 1'b0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready32", 64'(r32), 64'(0));
    chk("rst_out_valid32", 64'(ov32), 64'(0));
    chk("rst_out_data32", 64'(od32), 64'(0));
    chk("rst_out_datak32", 64'(ok32), 64'(0));
    chk("rst_skp_active32", 64'(sk32), 64'(0));
    chk("rst_in_ready8", 64'(r8), 64'(0));
    chk("rst_out_valid8", 64'(ov8), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    #1 chk("in_ready_at_release", 64'(r32), 64'(0));
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(r32), 64'(1));

    // One-cycle latency through an empty FIFO
    v32 = 1'b1; d32 = 32'hA5A5_0001; k32 = 4'h1;
    exp32(d32, k32);
    @(posedge clk); #1;
    v32 = 1'b0;
    chk("latency_valid", 64'(ov32), 64'(1));
    chk("latency_data", 64'(od32), 64'(32'hA5A5_0001));
    drain("latency");

    // W=32 stream: 89 data words precede the first SKP word
    do_reset();
    for (int i = 0; i < 100; i++)
      send32(32'h1000_0000 + i, (i % 7 == 3) ? 4'b0010 : 4'b0000);
    drain("stream32");
    chk("u32_words_before_skp", 64'(pre32), 64'(89));
    chk("u32_skp_words", 64'(skp32_seen), 64'(1));

    // W=32 backpressure: FIFO fills, output holds, then drains in order
    or32 = 1'b0; v32 = 1'b1; d32 = 32'h2000_0000; k32 = 4'h0;
    stable = 1'b1; acc = 0; cap = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) cap = {ok32, od32};
      else if (c > 2 && {ok32, od32} !== cap) stable = 1'b0;
      if (r32) begin exp32(d32, k32); acc++; end
      @(posedge clk); #1;
      if (acc > 0 && d32 == 32'h2000_0000 + acc - 1) d32 = 32'h2000_0000 + acc;
    end
    v32 = 1'b0;
    chk("stall_in_ready", 64'(r32), 64'(0));
    chk("stall_out_valid", 64'(ov32), 64'(1));
    chk("stall_out_stable", 64'(stable), 64'(1));
    or32 = 1'b1;
    drain("stall32");

    // enable low: 1000 words, no SKP
    en32 = 1'b0;
    for (int i = 0; i < 1000; i++) send32(32'h3000_0000 + i, 4'h0);
    drain("noskp32");
    chk("u32_skp_with_enable_low", 64'(skp32_seen), 64'(1));
    en32 = 1'b1;

    // W=8: 354 bytes then four K28.1 beats
    do_reset();
    for (int i = 0; i < 360; i++) send8(8'(i), (i % 50 == 0));
    drain("stream8");
    chk("u8_bytes_before_skp", 64'(pre8), 64'(354));
    chk("u8_skp_beats", 64'(skp8_seen), 64'(4));

    // Drop enable during the first beat: remaining beats still go out
    for (int i = 0; i < 348; i++) send8(8'h40 + 8'(i % 16), 1'b0);
    wait_skp8("mid_skp_enable_start");
    en8 = 1'b0;
    drain("endrop8");
    chk("u8_skp_beats_after_enable_drop", 64'(skp8_seen), 64'(8));
    en8 = 1'b1;

    // Reset during beat 2 of a set
    do_reset();
    for (int i = 0; i < 354; i++) send8(8'h80 + 8'(i % 32), 1'b0);
    wait_skp8("reset_skp_start");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov8), 64'(0));
    chk("midrst_out_data", 64'(od8), 64'(0));
    chk("midrst_out_datak", 64'(ok8), 64'(0));
    chk("midrst_skp_active", 64'(sk8), 64'(0));
    q8.delete(); q32.delete(); bytes8 = 0; skp8_seen = 0; pre8 = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 360; i++) send8(8'hC0 + 8'(i % 16), 1'b0);
    drain("postrst8");
    chk("postrst_bytes_before_skp", 64'(pre8), 64'(354));
    chk("postrst_skp_beats", 64'(skp8_seen), 64'(4));

`ifdef PIPE_SKP_STATS_EN
    // 3540 bytes at W=8 gives ten complete sets
    do_reset();
    for (int i = 0; i < 3540; i++) send8(8'(i), 1'b0);
    drain("stats8");
    chk("skp_os_count8", 64'(os8), 64'(10));
    chk("skp_os_count32_idle", 64'(os32), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
